// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Multi-cycle instruction fetch stage. Holds the PC, drives the instruction
//   ROM strobes for WAIT_CYCLES+1 cycles, captures the ROM word into the IR
//   and offers it to the decoder through an ir_valid/ir_ack handshake. On
//   each accepted instruction the PC advances by 4 or takes a redirect
//   target (same-cycle redirect beats a pending one, both beat PC+4). A
//   misaligned target parks the unit in ERR until reset.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   fetch_en           permit new fetches
//   rom_nce/rom_re     ROM chip enable (active-low) / read enable
//   rom_addr           ROM byte address, pc[ADDR_W-1:0]
//   rom_data           ROM read data
//   ir, ir_valid       instruction register and its valid flag
//   ir_ack             consumer accepts the IR
//   redirect,
//   redirect_pc        branch/jump request and target
//   pc, pc_plus4       current PC and PC+4
//   misalign_err       sticky misaligned-target flag
//   fetch_cnt          (FETCH_COUNT_EN only) saturating accepted-ack count
//
// Configuration macro: FETCH_COUNT_EN
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic              rom_nce,
    output logic              rom_re,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       ir,
    output logic              ir_valid,
    input  logic              ir_ack,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              misalign_err
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]       fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_ERR
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t            state, state_next;
    logic [3:0]        cnt;
    logic              pend_vld;
    logic [31:0]       pend_pc;
    logic [ADDR_W-1:0] addr_q;

    logic              accept;
    logic              fetch_done;
    logic [31:0]       target;
    logic              misalign;

    assign pc_plus4   = pc + 32'd4;
    assign accept     = (state == S_HOLD) && ir_ack;
    assign fetch_done = (state == S_FETCH) && (cnt == WAIT_LAST);
    assign target     = redirect ? redirect_pc : (pend_vld ? pend_pc : pc_plus4);
    assign misalign   = (target[1:0] != 2'b00);

    // Strobes are pure state decodes; the address follows the PC during
    // FETCH and otherwise holds the last address presented.
    assign rom_nce  = (state != S_FETCH);
    assign rom_re   = (state == S_FETCH);
    assign rom_addr = (state == S_FETCH) ? pc[ADDR_W-1:0] : addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (fetch_en)   state_next = S_FETCH;
            S_FETCH: if (fetch_done) state_next = S_HOLD;
            S_HOLD: begin
                if (ir_ack) begin
                    if (misalign)      state_next = S_ERR;
                    else if (fetch_en) state_next = S_FETCH;
                    else               state_next = S_IDLE;
                end
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            ir           <= '0;
            ir_valid     <= 1'b0;
            misalign_err <= 1'b0;
            cnt          <= '0;
            pend_vld     <= 1'b0;
            pend_pc      <= '0;
            addr_q       <= '0;
        end else begin
            // Counter sits at zero outside FETCH, which gives the zero start
            // on every entry into FETCH.
            if (state == S_FETCH) cnt <= cnt + 4'd1;
            else                  cnt <= '0;

            if (state == S_FETCH) addr_q <= pc[ADDR_W-1:0];

            if (fetch_done) begin
                ir       <= rom_data;
                ir_valid <= 1'b1;
            end

            if (accept) begin
                ir_valid <= 1'b0;
                pend_vld <= 1'b0;
                if (misalign) misalign_err <= 1'b1;
                else          pc           <= target;
            end else if (redirect) begin
                pend_vld <= 1'b1;
                pend_pc  <= redirect_pc;
            end
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_cnt <= '0;
        else if (accept && !misalign && (fetch_cnt != 16'hFFFF))
            fetch_cnt <= fetch_cnt + 16'd1;
    end
`endif

endmodule
